// File: rtl/disp_pkg.sv
// Shared types and defaults for the display message scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } disp_state_t;

  localparam int CNT_W           = 26;
  localparam int MAX_TICKS       = (1 << CNT_W) - 1;
  localparam int HOLD_TICKS_DEF  = 50_000_000;
  localparam int BLINK_TICKS_DEF = 12_500_000;

endpackage

// File: rtl/disp_hold_timer.sv
// Reloadable 26-bit down-counter; stops at zero and flags it.
module disp_hold_timer
  import disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)                  count <= '0;
    else if (load)              count <= load_val;
    else if (en && count != '0) count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/disp_sched.sv
// Two-source message scheduler for a 4-digit display; A preempts B, base shown when idle.
// Optional decimal-point blink during messages: define DISP_SCHED_BLINK_EN.
module disp_sched
  import disp_pkg::*;
#(
  parameter int HOLD_TICKS  = HOLD_TICKS_DEF,
  parameter int BLINK_TICKS = BLINK_TICKS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] base_hex,
  input  logic [3:0]  base_dp,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic [3:0]  dp_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic [3:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        busy,
  output logic [3:0]  hex3,
  output logic [3:0]  hex2,
  output logic [3:0]  hex1,
  output logic [3:0]  hex0,
  output logic [3:0]  dp_out
);

  if (HOLD_TICKS < 1 || HOLD_TICKS > MAX_TICKS) begin : g_bad_hold
    $error("disp_sched: HOLD_TICKS out of range");
  end
  if (BLINK_TICKS < 1 || BLINK_TICKS > MAX_TICKS) begin : g_bad_blink
    $error("disp_sched: BLINK_TICKS out of range");
  end

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS - 1);

  disp_state_t state, state_nxt;
  logic        grant;
  logic        showing;
  logic        hold_zero;
  logic [15:0] msg_hex, msg_hex_nxt;
  logic [3:0]  msg_dp, msg_dp_nxt;
  logic [3:0]  blink_mask;

  assign showing = (state != IDLE);
  assign grant   = gnt_a | gnt_b;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_a       = !reset && req_a && (state != SHOW_A);
    gnt_b       = !reset && req_b && !req_a && (state == IDLE);
    state_nxt   = state;
    msg_hex_nxt = msg_hex;
    msg_dp_nxt  = msg_dp;
    if (gnt_a) begin
      state_nxt   = SHOW_A;
      msg_hex_nxt = data_a;
      msg_dp_nxt  = dp_a;
    end else if (gnt_b) begin
      state_nxt   = SHOW_B;
      msg_hex_nxt = data_b;
      msg_dp_nxt  = dp_b;
    end else if (showing && hold_zero) begin
      state_nxt = IDLE;
    end
  end

  disp_hold_timer u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (HOLD_LOAD),
    .en       (showing),
    .zero     (hold_zero)
  );

`ifdef DISP_SCHED_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LOAD = CNT_W'(BLINK_TICKS - 1);

  logic phase, phase_nxt, blink_zero, blink_wrap;

  assign blink_wrap = showing && blink_zero;

  disp_hold_timer u_blink (
    .clk      (clk),
    .reset    (reset),
    .load     (grant || blink_wrap),
    .load_val (BLINK_LOAD),
    .en       (showing),
    .zero     (blink_zero)
  );

  always_comb begin
    phase_nxt = phase;
    if (grant)           phase_nxt = 1'b0;
    else if (blink_wrap) phase_nxt = ~phase;
  end

  always_ff @(posedge clk) begin
    if (reset) phase <= 1'b0;
    else       phase <= phase_nxt;
  end

  assign blink_mask = {4{phase_nxt}};
`else
  assign blink_mask = 4'h0;
`endif

  // Outputs are loaded from next-state values so they track the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      msg_hex                <= '0;
      msg_dp                 <= 4'hF;
      busy                   <= 1'b0;
      {hex3, hex2, hex1, hex0} <= '0;
      dp_out                 <= 4'hF;
    end else begin
      state   <= state_nxt;
      msg_hex <= msg_hex_nxt;
      msg_dp  <= msg_dp_nxt;
      busy    <= (state_nxt != IDLE);
      if (state_nxt == IDLE) begin
        {hex3, hex2, hex1, hex0} <= base_hex;
        dp_out                   <= base_dp;
      end else begin
        {hex3, hex2, hex1, hex0} <= msg_hex_nxt;
        dp_out                   <= msg_dp_nxt | blink_mask;
      end
    end
  end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 The block SHALL have parameter HOLD_TICKS, default 50_000_000, giving message display time in clk cycles (1 s at 50 MHz); legal range is 1 to 2^26-1.
REQ-002 The block SHALL have parameter BLINK_TICKS, default 12_500_000, giving the decimal-point blink half-period in cycles; legal range is 1 to 2^26-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port base_hex, input, 16 bits: background digits, [15:12] is digit 3.
REQ-006 The block SHALL have port base_dp, input, 4 bits: background decimal points, active-low.
REQ-007 The block SHALL have port req_a, input, 1 bit: high-priority message request, level.
REQ-008 The block SHALL have ports data_a / dp_a, inputs, 16 / 4 bits: message A digits and points, sampled on grant.
REQ-009 The block SHALL have port req_b, input, 1 bit: low-priority message request, level.
REQ-010 The block SHALL have ports data_b / dp_b, inputs, 16 / 4 bits: message B digits and points, sampled on grant.
REQ-011 The block SHALL have ports gnt_a / gnt_b, outputs, 1 bit each: one-cycle accept pulses.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a message is shown.
REQ-013 The block SHALL have ports hex3, hex2, hex1, hex0, outputs, 4 bits each, registered: feed to the display multiplexer.
REQ-014 The block SHALL have port dp_out, output, 4 bits, registered: active-low points to the display multiplexer.

Function
REQ-015 The FSM SHALL have states IDLE, SHOW_A and SHOW_B.
REQ-016 In IDLE with req_a=1, the block SHALL pulse gnt_a, latch data_a/dp_a, load hold counter with HOLD_TICKS-1, and enter SHOW_A.
REQ-017 In IDLE with req_a=0 and req_b=1, the block SHALL do the same for B, entering SHOW_B; A wins when both are asserted.
REQ-018 In SHOW_B, req_a=1 SHALL preempt: gnt_a pulses, A is latched, the counter reloads, and the state becomes SHOW_A; B is dropped without a second grant.
REQ-019 In SHOW_A, all requests SHALL be ignored (no grant); in SHOW_B, req_b SHALL be ignored.
REQ-020 In SHOW states the counter SHALL decrement each cycle; a cycle with counter==0 SHALL move the FSM to IDLE, so a message is shown exactly HOLD_TICKS cycles.
REQ-021 A new grant from IDLE SHALL occur no earlier than the cycle after returning to IDLE; back-to-back messages therefore have one base-display cycle between them.
REQ-022 Outputs SHALL have 1-cycle latency: the hex*/dp_out registers take the latched message in SHOW states and base_hex/base_dp in IDLE.
REQ-023 busy SHALL equal (state != IDLE), registered with the same timing as hex*.
REQ-024 gnt_a and gnt_b SHALL never be high in the same cycle and SHALL be high for one cycle per accept.

Reset
REQ-025 While reset=1 at a clk edge, the block SHALL set: state=IDLE, counters=0, hex3..hex0=0, dp_out=4'hF, gnt_a=gnt_b=0, busy=0.
REQ-026 Reset SHALL take priority over all requests; asserting reset mid-message SHALL abandon the message, with no grant in that cycle.

Configuration
REQ-027 With DISP_SCHED_BLINK_EN defined, a blink phase bit SHALL clear on each grant and toggle every BLINK_TICKS cycles in SHOW states; dp_out SHALL be the latched dp OR'd with {4{phase}}.
REQ-028 Without DISP_SCHED_BLINK_EN, no blink logic SHALL exist and dp_out SHALL equal the latched dp in SHOW states.

Structure
REQ-029 Package disp_pkg SHALL hold the state enum and the default HOLD_TICKS/BLINK_TICKS constants.
REQ-030 The reloadable down-counter SHALL be sub-module disp_hold_timer, with load, load value, enable, zero flag and a 26-bit width; it is instantiated for hold and for blink.

Verification (HOLD_TICKS=8, BLINK_TICKS=2)
REQ-031 Scenario: reset, then req_a=1 at cycle 2 with data_a=16'h1234 → gnt_a at cycle 2, hex3..0=1,2,3,4 from cycle 3 through 10, base value at cycle 11.
REQ-032 Scenario: req_a and req_b both asserted in IDLE → only gnt_a; data_a shown; no gnt_b while req_a is being displayed.
REQ-033 Scenario: B shown, req_a pulse at 4th B cycle → gnt_a, A shown for a full 8 cycles, B not resumed.
REQ-034 Scenario: req_b held continuously → gnt_b every 9 cycles, with base digits visible for 1 cycle between messages.
REQ-035 Scenario: reset asserted at the 5th cycle of a message → next cycle hex=0, dp_out=F, busy=0; a held request is re-granted the cycle after reset deasserts.
REQ-036 Scenario (blink build): dp_a=4'h0 → dp_out sequence 0,0,F,F,0,0,F,F over the message.
